// File: rtl/dzcpu_useq_engine_pkg.sv
// Shared definitions for the dzcpu microcode sequencer: control codes,
// field widths, page constants and sequencer states.
package dzcpu_useq_engine_pkg;

  localparam int CTL_W = 3;

  localparam logic [CTL_W-1:0] SEQ_NEXT   = 3'd0;
  localparam logic [CTL_W-1:0] SEQ_EOF    = 3'd1;
  localparam logic [CTL_W-1:0] SEQ_EOF_Z  = 3'd2;
  localparam logic [CTL_W-1:0] SEQ_EOF_NZ = 3'd3;
  localparam logic [CTL_W-1:0] SEQ_PAGE   = 3'd4;

  localparam int PAGE_MAIN = 0;
  localparam int PAGE_CB   = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } useq_state_e;

  function automatic int pg_width(input int npage);
    return (npage > 1) ? $clog2(npage) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dzcpu_useq_engine_ram.sv
// Single-write-port table used for both dispatch (async read) and
// microcode store (registered, read-first).
module dzcpu_useq_ram #(
  parameter int DW        = 8,
  parameter int AW        = 8,
  parameter bit SYNC_READ = 1'b1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          ren,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  if (SYNC_READ) begin : g_sync
    // Non-blocking write above means a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
      if (ren) rdata <= mem[raddr];
    end
  end else begin : g_async
    logic unused_ren;
    assign unused_ren = ren;
    assign rdata      = mem[raddr];
  end

endmodule

// File: rtl/dzcpu_useq_engine.sv
// Microcode sequencer: paged opcode dispatch, writable microcode store,
// micro-PC stepping with EOF / conditional EOF / page-switch control codes.
module dzcpu_useq_engine
  import dzcpu_useq_engine_pkg::*;
#(
  parameter  int UOP_W  = 13,
  parameter  int UPC_W  = 8,
  parameter  int NPAGE  = 2,
  parameter  int OP_W   = 8,
  localparam int PG_W   = pg_width(NPAGE),
  localparam int CFG_AW = max2(PG_W + OP_W, UPC_W)
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic [OP_W-1:0]   iMop,
  input  logic              iMopValid,
  output logic              oMopReady,
  input  logic              iStall,
  input  logic              iFlagZ,
  input  logic              iCfgWe,
  input  logic              iCfgSel,
  input  logic [CFG_AW-1:0] iCfgAddr,
  input  logic [UOP_W-1:0]  iCfgData,
  output logic [UOP_W-1:0]  oUop,
  output logic              oUopValid,
  output logic [UPC_W-1:0]  oUpc,
  output logic              oEof,
  output logic [PG_W-1:0]   oPage
);

  useq_state_e      state_q, state_d;
  logic [PG_W-1:0]  page_q, page_d;
  logic [UPC_W-1:0] upc_q, upc_d;
  logic [UOP_W-1:0] store_word;
  logic [UPC_W-1:0] disp_entry;
  logic [CTL_W-1:0] ctl;
  logic             run, uop_term, term, ready, accept, store_ren;
  logic             disp_we, store_we;

  assign run = (state_q == ST_RUN);
  // The store's read register is not cleared; idle output is masked instead.
  assign oUop = run ? store_word : '0;
  assign ctl  = oUop[UOP_W-1 -: CTL_W];

  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    upc_d     = upc_q;
    store_ren = 1'b0;
    uop_term  = 1'b0;
    case (ctl)
      SEQ_EOF, SEQ_PAGE: uop_term = 1'b1;
      SEQ_EOF_Z:         uop_term = iFlagZ;
      SEQ_EOF_NZ:        uop_term = ~iFlagZ;
      default:           uop_term = 1'b0;
    endcase
    term   = run & ~iStall & uop_term;
    ready  = ~iStall & (~run | term);
    accept = iMopValid & ready;
    if (accept) begin
      // The incoming opcode still dispatches through the current page.
      state_d   = ST_RUN;
      upc_d     = disp_entry;
      store_ren = 1'b1;
      page_d    = (term && ctl == SEQ_PAGE) ? oUop[PG_W-1:0] : PG_W'(PAGE_MAIN);
    end else if (term) begin
      state_d = ST_IDLE;
      if (ctl == SEQ_PAGE) page_d = oUop[PG_W-1:0];
    end else if (run && !iStall) begin
      upc_d     = upc_q + UPC_W'(1);
      store_ren = 1'b1;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= ST_IDLE;
      page_q  <= '0;
      upc_q   <= '0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      upc_q   <= upc_d;
    end
  end

  assign disp_we  = iCfgWe & ~iCfgSel & ~iReset;
  assign store_we = iCfgWe &  iCfgSel & ~iReset;

  dzcpu_useq_ram #(
    .DW        (UPC_W),
    .AW        (PG_W + OP_W),
    .SYNC_READ (1'b0)
  ) u_disp (
    .clk   (iClock),
    .we    (disp_we),
    .waddr (iCfgAddr[PG_W+OP_W-1:0]),
    .wdata (iCfgData[UPC_W-1:0]),
    .ren   (1'b0),
    .raddr ({page_q, iMop}),
    .rdata (disp_entry)
  );

  dzcpu_useq_ram #(
    .DW        (UOP_W),
    .AW        (UPC_W),
    .SYNC_READ (1'b1)
  ) u_store (
    .clk   (iClock),
    .we    (store_we),
    .waddr (iCfgAddr[UPC_W-1:0]),
    .wdata (iCfgData),
    .ren   (store_ren & ~iReset),
    .raddr (upc_d),
    .rdata (store_word)
  );

  assign oUopValid = run;
  assign oUpc      = upc_q;
  assign oEof      = term;
  assign oMopReady = ready;
  assign oPage     = page_q;

endmodule

// File: tb/tb_dzcpu_useq_engine.sv
// Directed bench for dzcpu_useq_engine: flows, conditional end, paging,
// stall, wrap, reset mid-flow and read-first store behaviour.
`timescale 1ns/1ps
module tb_dzcpu_useq_engine;
  import dzcpu_useq_engine_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mop_valid, stall, flag_z, cfg_we, cfg_sel;
  logic [7:0]  mop;
  logic [8:0]  cfg_addr;
  logic [12:0] cfg_data;
  logic        mop_ready, uop_valid, eof;
  logic [12:0] uop;
  logic [7:0]  upc;
  logic [0:0]  page;

  int n_cmp = 0;
  int n_bad = 0;
  logic [12:0] model [256];

  dzcpu_useq_engine dut (
    .iClock    (clk),
    .iReset    (rst),
    .iMop      (mop),
    .iMopValid (mop_valid),
    .oMopReady (mop_ready),
    .iStall    (stall),
    .iFlagZ    (flag_z),
    .iCfgWe    (cfg_we),
    .iCfgSel   (cfg_sel),
    .iCfgAddr  (cfg_addr),
    .iCfgData  (cfg_data),
    .oUop      (uop),
    .oUopValid (uop_valid),
    .oUpc      (upc),
    .oEof      (eof),
    .oPage     (page)
  );

  task automatic wr_store(input int a, input logic [2:0] c, input logic [9:0] pl);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 9'(a); cfg_data = {c, pl};
    model[a] = {c, pl};
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic us(input int a, input logic [2:0] c);
    wr_store(a, c, 10'h100 | 10'(a));
  endtask

  task automatic wr_disp(input logic pg, input logic [7:0] op, input int target);
    @(negedge clk);
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = {pg, op}; cfg_data = 13'(target);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic load_tables;
    wr_disp(1'b0, 8'h31, 5);
    us(5, SEQ_NEXT); us(6, SEQ_NEXT); us(7, SEQ_NEXT); us(8, SEQ_EOF);
    wr_disp(1'b0, 8'h40, 17);
    us(17, SEQ_NEXT); us(18, SEQ_NEXT); us(19, SEQ_EOF_Z);
    us(20, SEQ_NEXT); us(21, SEQ_NEXT); us(22, SEQ_EOF);
    wr_disp(1'b0, 8'hCB, 13);
    us(13, SEQ_NEXT); us(14, SEQ_NEXT);
    wr_store(15, SEQ_PAGE, 10'h0F0 | 10'(PAGE_CB));
    us(16, SEQ_EOF);
    wr_disp(1'b1, 8'h7C, 16);
    wr_disp(1'b0, 8'h7C, 16);
    wr_disp(1'b0, 8'h7D, 40);
    wr_disp(1'b1, 8'h7D, 44);
    us(40, SEQ_EOF); us(44, SEQ_EOF);
    wr_disp(1'b0, 8'h50, 53);
    us(53, SEQ_NEXT); us(54, SEQ_NEXT); us(55, SEQ_EOF);
    wr_disp(1'b0, 8'h60, 255);
    us(255, SEQ_NEXT); us(0, SEQ_EOF);
    wr_disp(1'b0, 8'h70, 1);
    us(1, SEQ_NEXT); us(2, SEQ_NEXT); us(3, SEQ_EOF);
    wr_disp(1'b0, 8'h80, 60);
    us(60, SEQ_NEXT);
    wr_store(61, SEQ_EOF, 10'h13D);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    n_cmp++; if (uop !== 13'd0) begin n_bad++; $display("FAIL reset_uop got %h want 0", uop); end
    n_cmp++; if (upc !== 8'd0) begin n_bad++; $display("FAIL reset_upc got %0d want 0", upc); end
    n_cmp++; if (uop_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", uop_valid); end
    n_cmp++; if (page !== 1'b0) begin n_bad++; $display("FAIL reset_page got %b want 0", page); end
    n_cmp++; if (eof !== 1'b0) begin n_bad++; $display("FAIL reset_eof got %b want 0", eof); end
    n_cmp++; if (mop_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", mop_ready); end
    stall = 1'b1; #1;
    n_cmp++; if (mop_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_stall got %b want 0", mop_ready); end
    stall = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_basic_flow;
    @(negedge clk); mop = 8'h31; mop_valid = 1'b1; #1;
    n_cmp++; if (mop_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready_idle got %b want 1", mop_ready); end
    @(negedge clk); mop_valid = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (upc !== 8'(5 + i)) begin n_bad++; $display("FAIL basic_upc got %0d want %0d", upc, 5 + i); end
      n_cmp++; if (uop !== model[5 + i]) begin n_bad++; $display("FAIL basic_uop got %h want %h", uop, model[5 + i]); end
      n_cmp++; if (eof !== (i == 3)) begin n_bad++; $display("FAIL basic_eof got %b want %b at upc %0d", eof, (i == 3), upc); end
      n_cmp++; if (uop_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %b want 1", uop_valid); end
      @(negedge clk); #1;
    end
    n_cmp++; if (uop_valid !== 1'b0) begin n_bad++; $display("FAIL basic_idle_valid got %b want 0", uop_valid); end
    n_cmp++; if (uop !== 13'd0) begin n_bad++; $display("FAIL basic_idle_uop got %h want 0", uop); end
  endtask

  task automatic test_cond_end;
    for (int z = 1; z >= 0; z--) begin
      int n;
      n = (z == 1) ? 3 : 6;
      @(negedge clk); flag_z = z[0]; mop = 8'h40; mop_valid = 1'b1;
      @(negedge clk); mop_valid = 1'b0; #1;
      for (int i = 0; i < n; i++) begin
        n_cmp++; if (upc !== 8'(17 + i)) begin n_bad++; $display("FAIL cond_upc z=%0d got %0d want %0d", z, upc, 17 + i); end
        n_cmp++; if (eof !== (i == n - 1)) begin n_bad++; $display("FAIL cond_eof z=%0d got %b want %b at upc %0d", z, eof, (i == n - 1), upc); end
        @(negedge clk); #1;
      end
      n_cmp++; if (uop_valid !== 1'b0) begin n_bad++; $display("FAIL cond_idle z=%0d got %b want 0", z, uop_valid); end
    end
    flag_z = 1'b0;
  endtask

  task automatic test_back_to_back;
    @(negedge clk); mop = 8'hCB; mop_valid = 1'b1;
    @(negedge clk); mop = 8'h7C; #1;
    n_cmp++; if (upc !== 8'd13) begin n_bad++; $display("FAIL b2b_upc13 got %0d want 13", upc); end
    n_cmp++; if (mop_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready13 got %b want 0", mop_ready); end
    @(negedge clk); #1;
    n_cmp++; if (upc !== 8'd14) begin n_bad++; $display("FAIL b2b_upc14 got %0d want 14", upc); end
    @(negedge clk); #1;
    n_cmp++; if (upc !== 8'd15) begin n_bad++; $display("FAIL b2b_upc15 got %0d want 15", upc); end
    n_cmp++; if (eof !== 1'b1) begin n_bad++; $display("FAIL b2b_eof15 got %b want 1", eof); end
    n_cmp++; if (mop_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready15 got %b want 1", mop_ready); end
    n_cmp++; if (page !== 1'b0) begin n_bad++; $display("FAIL b2b_page15 got %b want 0", page); end
    @(negedge clk); mop = 8'h7D; #1;
    n_cmp++; if (upc !== 8'd16) begin n_bad++; $display("FAIL b2b_upc16 got %0d want 16", upc); end
    n_cmp++; if (page !== 1'b1) begin n_bad++; $display("FAIL b2b_page16 got %b want 1", page); end
    n_cmp++; if (eof !== 1'b1) begin n_bad++; $display("FAIL b2b_eof16 got %b want 1", eof); end
    @(negedge clk); mop_valid = 1'b0; #1;
    n_cmp++; if (upc !== 8'd44) begin n_bad++; $display("FAIL b2b_cb_dispatch got %0d want 44", upc); end
    n_cmp++; if (page !== 1'b0) begin n_bad++; $display("FAIL b2b_page_back got %b want 0", page); end
    @(negedge clk); #1;
    n_cmp++; if (uop_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle got %b want 0", uop_valid); end
  endtask

  task automatic test_stall;
    @(negedge clk); mop = 8'h50; mop_valid = 1'b1;
    @(negedge clk); mop_valid = 1'b0; #1;
    n_cmp++; if (upc !== 8'd53) begin n_bad++; $display("FAIL stall_upc53 got %0d want 53", upc); end
    @(negedge clk); stall = 1'b1; #1;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) begin @(negedge clk); if (j == 3) stall = 1'b0; #1; end
      n_cmp++; if (upc !== 8'd54) begin n_bad++; $display("FAIL stall_hold got %0d want 54 (cycle %0d)", upc, j); end
      n_cmp++; if (mop_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready got %b want 0 (cycle %0d)", mop_ready, j); end
    end
    @(negedge clk); stall = 1'b1; #1;
    n_cmp++; if (upc !== 8'd55) begin n_bad++; $display("FAIL stall_resume got %0d want 55", upc); end
    n_cmp++; if (eof !== 1'b0) begin n_bad++; $display("FAIL stall_eof_masked got %b want 0", eof); end
    stall = 1'b0; #1;
    n_cmp++; if (eof !== 1'b1) begin n_bad++; $display("FAIL stall_eof got %b want 1", eof); end
    @(negedge clk); stall = 1'b1; mop = 8'h31; mop_valid = 1'b1; #1;
    n_cmp++; if (mop_ready !== 1'b0) begin n_bad++; $display("FAIL stall_idle_ready got %b want 0", mop_ready); end
    @(negedge clk); #1;
    n_cmp++; if (uop_valid !== 1'b0) begin n_bad++; $display("FAIL stall_idle_accept got %b want 0", uop_valid); end
    mop_valid = 1'b0; stall = 1'b0;
  endtask

  task automatic test_wrap;
    @(negedge clk); mop = 8'h60; mop_valid = 1'b1;
    @(negedge clk); mop_valid = 1'b0; #1;
    n_cmp++; if (upc !== 8'd255) begin n_bad++; $display("FAIL wrap_upc255 got %0d want 255", upc); end
    n_cmp++; if (uop !== model[255]) begin n_bad++; $display("FAIL wrap_uop255 got %h want %h", uop, model[255]); end
    @(negedge clk); #1;
    n_cmp++; if (upc !== 8'd0) begin n_bad++; $display("FAIL wrap_upc0 got %0d want 0", upc); end
    n_cmp++; if (uop !== model[0]) begin n_bad++; $display("FAIL wrap_uop0 got %h want %h", uop, model[0]); end
    n_cmp++; if (eof !== 1'b1) begin n_bad++; $display("FAIL wrap_eof got %b want 1", eof); end
    @(negedge clk); #1;
  endtask

  task automatic test_reset_midflow;
    @(negedge clk); mop = 8'h70; mop_valid = 1'b1;
    @(negedge clk); mop_valid = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (upc !== 8'd2) begin n_bad++; $display("FAIL rstmid_upc2 got %0d want 2", upc); end
    rst = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (upc !== 8'd0) begin n_bad++; $display("FAIL rstmid_upc got %0d want 0", upc); end
    n_cmp++; if (uop_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %b want 0", uop_valid); end
    n_cmp++; if (uop !== 13'd0) begin n_bad++; $display("FAIL rstmid_uop got %h want 0", uop); end
    n_cmp++; if (eof !== 1'b0) begin n_bad++; $display("FAIL rstmid_eof got %b want 0", eof); end
    rst = 1'b0;
    @(negedge clk); mop = 8'h70; mop_valid = 1'b1;
    @(negedge clk); mop_valid = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (upc !== 8'(1 + i)) begin n_bad++; $display("FAIL rstmid_replay got %0d want %0d", upc, 1 + i); end
      n_cmp++; if (uop !== model[1 + i]) begin n_bad++; $display("FAIL rstmid_replay_uop got %h want %h", uop, model[1 + i]); end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_read_first;
    @(negedge clk); mop = 8'h80; mop_valid = 1'b1;
    @(negedge clk); mop_valid = 1'b0;
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 9'd61; cfg_data = {SEQ_EOF, 10'h2AA}; #1;
    n_cmp++; if (upc !== 8'd60) begin n_bad++; $display("FAIL rdfirst_upc60 got %0d want 60", upc); end
    @(negedge clk); cfg_we = 1'b0; #1;
    n_cmp++; if (upc !== 8'd61) begin n_bad++; $display("FAIL rdfirst_upc61 got %0d want 61", upc); end
    n_cmp++; if (uop !== {SEQ_EOF, 10'h13D}) begin n_bad++; $display("FAIL rdfirst_old got %h want %h", uop, {SEQ_EOF, 10'h13D}); end
    @(negedge clk); mop = 8'h80; mop_valid = 1'b1;
    @(negedge clk); mop_valid = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (uop !== {SEQ_EOF, 10'h2AA}) begin n_bad++; $display("FAIL rdfirst_new got %h want %h", uop, {SEQ_EOF, 10'h2AA}); end
    @(negedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mop = 8'd0; mop_valid = 1'b0; stall = 1'b0; flag_z = 1'b0;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = 9'd0; cfg_data = 13'd0;
    test_reset;
    load_tables;
    test_basic_flow;
    test_cond_end;
    test_back_to_back;
    test_stall;
    test_wrap;
    test_reset_midflow;
    test_read_first;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
